// File: rtl/ram_fifo_pkg.sv
// Shared defaults and types for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int RAM_FIFO_DATA_WIDTH = 14;
  localparam int RAM_FIFO_ADDR_WIDTH = 6;

  // Pointers carry one extra bit so that full and empty can be told apart.
  typedef logic [RAM_FIFO_ADDR_WIDTH:0]   ram_fifo_ptr_t;
  // Occupancy covers the RAM, one in-flight read and the 2-entry output buffer.
  typedef logic [RAM_FIFO_ADDR_WIDTH+1:0] ram_fifo_cnt_t;

endpackage

// File: rtl/ram_fifo_out_buf.sv
// Two-entry ordered output buffer that absorbs the RAM read latency.
// ent0 is always the head; a simultaneous push and pop keeps ordering.
module ram_fifo_out_buf
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            cnt
);

  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;

  // Entry shifting and occupancy; pop is only ever asserted with cnt != 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= data_in;
          else             ent1 <= data_in;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= data_in;
          end else begin
            ent0 <= ent1;
            ent1 <= data_in;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign data_out = ent0;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapped around an external simple dual-port RAM.
// Owns write/read pointers, the single in-flight read and flow control.
// Optional macro RAM_FIFO_BYPASS_EN: when the RAM path is empty, accepted
// words go straight into the output buffer (1-cycle latency).
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH+1:0] count
);

  localparam logic [ADDR_WIDTH:0] RAM_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic                  inflight;
  logic                  accept;
  logic                  pop;
  logic                  issue;
  logic                  bypass;
  logic                  ob_push;
  logic [DATA_WIDTH-1:0] ob_din;
  logic [1:0]            ob_cnt;
  logic [2:0]            ob_pending;

  // Modulo arithmetic on the extended pointers gives 0..2**ADDR_WIDTH.
  assign ram_cnt  = wr_ptr - rd_ptr;
  assign in_ready = !rst && (ram_cnt != RAM_DEPTH);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Words that will sit in the output buffer next cycle without a new read.
  assign ob_pending = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};

  // Read issue and bypass decisions.
  always_comb begin
    issue  = (ram_cnt != '0) && (ob_pending <= 3'd1);
    bypass = 1'b0;
`ifdef RAM_FIFO_BYPASS_EN
    bypass = accept && (ram_cnt == '0) && !inflight &&
             ((ob_cnt - {1'b0, pop}) < 2'd2);
`endif
  end

  assign mem_wr_en   = accept && !bypass;
  assign mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign mem_wr_data = in_data;
  assign mem_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  // The returning read and a bypass word never coincide (bypass needs !inflight).
  assign ob_push = inflight || bypass;
  assign ob_din  = inflight ? mem_rd_data : in_data;

  // Pointer and in-flight tracking; reset drops any pending read result.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (mem_wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (issue)     rd_ptr <= rd_ptr + PTR_ONE;
      inflight <= issue;
    end
  end

  ram_fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (ob_push),
    .pop      (pop),
    .data_in  (ob_din),
    .data_out (out_data),
    .cnt      (ob_cnt)
  );

  assign out_valid = (ob_cnt != 2'd0);
  assign count     = {1'b0, ram_cnt}
                   + {{ADDR_WIDTH{1'b0}}, ob_cnt}
                   + {{(ADDR_WIDTH+1){1'b0}}, inflight};

endmodule
